issue_queue: RTL and testbench
==============================

# issue_queue

Out-of-order issue queue sitting directly downstream of the rename stage. It accepts renamed instructions (physical source/destination tags plus source-ready bits), captures wakeups broadcast on the common data bus, and each cycle issues the oldest entry whose sources are both ready to the execute stage. Slot allocation is out of order, and an age matrix enforces oldest-first selection.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two, 2..16)
- PREG_W, 5, physical register tag width
- OP_W, 8, opaque opcode/payload width carried through unchanged

Ports:
- clk_i  input  1  clock, all state on rising edge
- reset_ni  input  1  asynchronous, active-low reset
- flush_i  input  1  synchronous flush, clears all entries
- disp_valid_i  input  1  rename presents an instruction
- disp_ready_o  output  1  queue can accept; transfer when disp_valid_i & disp_ready_o
- disp_op_i  input  OP_W  payload
- disp_prs1_i, disp_prs2_i  input  PREG_W  physical source tags
- disp_prs1_rdy_i, disp_prs2_rdy_i  input  1  source ready at rename
- disp_prd_i  input  PREG_W  physical destination tag
- cdb_en_i  input  1  CDB broadcast valid
- cdb_reg_addr_i  input  PREG_W  tag being written back
- iss_valid_o  output  1  an entry is selected for issue
- iss_ready_i  input  1  execute accepts; transfer when iss_valid_o & iss_ready_i
- iss_op_o  output  OP_W, iss_prs1_o / iss_prs2_o / iss_prd_o  output  PREG_W  selected entry payload
- count_o  output  $clog2(DEPTH)+1  occupied entries

## Operation
- Per entry: valid, op, prs1, prs1_rdy, prs2, prs2_rdy, prd. Age matrix age[i][j] = 1 means entry i is older than entry j.
- Dispatch: on transfer, write the lowest-index free slot. Ready bits are captured as disp_prsN_rdy_i | (prsN == 0) | (cdb_en_i & cdb_reg_addr_i == prsN), so a same-cycle wakeup is never lost. Set age[j][k] = 1 for every valid j and age[k][*] = 0.
- Wakeup: each cycle with cdb_en_i, every valid entry whose prs1 or prs2 equals cdb_reg_addr_i sets the matching ready bit. Tag 0 always counts as ready.
- Select: entry i is eligible if it is valid and both ready bits are set. It is chosen if no other eligible j has age[j][i] = 1. iss_* outputs are combinational from the chosen entry. When nothing is eligible, iss_valid_o = 0 and payload outputs are 0.
- Issue: on transfer, the chosen entry's valid bit is cleared at the edge. Selection is recomputed every cycle, so the consumer must not rely on payload stability while iss_ready_i is low.
- disp_ready_o = (count < DEPTH) & reset_ni. It does not depend on a same-cycle issue.
- count_o: +1 on dispatch, -1 on issue, unchanged when both or neither occur.
- Flush: clears all valid bits and sets count to 0. It has priority over dispatch, issue and wakeup in the same cycle, and the dispatch in that cycle is dropped.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): all valid bits 0, count_o 0, iss_valid_o 0, iss payload 0, disp_ready_o 0 while reset_ni is low. disp_ready_o is 1 in the first cycle after release.
- Dispatch-to-issue latency: an entry written at edge N can issue no earlier than cycle N+1 (no dispatch-cycle bypass into select).
- Wakeup-to-issue latency: a CDB broadcast in cycle N makes the entry eligible in cycle N+1 (see Configuration).
- Full: DEPTH valid entries gives disp_ready_o = 0. An issue in that cycle frees a slot for the next cycle.
- Empty: iss_valid_o = 0. A simultaneous dispatch and issue cannot target the same entry.
- Reset asserted mid-operation: all in-flight entries are discarded immediately, with no partial issue.

## Configuration
- IQ_FAST_WAKEUP_EN defined: the select logic also treats sources matching the current-cycle CDB broadcast as ready. Wakeup-to-issue latency becomes 0 (eligible in cycle N), and iss_valid_o becomes combinationally dependent on cdb_en_i and cdb_reg_addr_i.
- Not defined: select uses only registered ready bits, giving a latency of 1 cycle and no combinational CDB-to-issue path.

## Test plan
- Reset: hold reset_ni low 3 cycles with disp_valid_i = 1 -> count_o 0, iss_valid_o 0, disp_ready_o 0; after release disp_ready_o 1.
- Ready dispatch: op 0x11, prs1 3 and prs2 4 both ready, prd 9, iss_ready_i 1 -> next cycle iss_valid_o 1 with op 0x11, prs 3/4, prd 9; count_o goes 1 then 0.
- Wakeup: dispatch with prs1 7 not ready; cdb_en_i with tag 7 in cycle 5 -> iss_valid_o in cycle 6 (cycle 5 with IQ_FAST_WAKEUP_EN). Also send a CDB tag 7 in the dispatch cycle itself -> the entry issues the next cycle.
- Full/backpressure: iss_ready_i 0, dispatch 8 ready entries -> disp_ready_o 0, count_o 8. Pulse iss_ready_i once -> count_o 7 and disp_ready_o 1.
- Age order: dispatch A (prs1 5 waiting), B (ready), C (ready) -> B issues first. Wake tag 5 in the next cycle -> A issues before C.
- Flush: 3 entries held plus dispatch and flush_i in the same cycle -> count_o 0, no issue the following cycle.

Source files
------------

// File: rtl/issue_queue_if.sv
// issue_queue_if: dispatch, CDB wakeup, issue and occupancy signals of the issue queue.
// master = rename/CDB/execute side, slave = the queue itself.
interface issue_queue_if #(
   parameter int DEPTH  = 8,
   parameter int PREG_W = 5,
   parameter int OP_W   = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              flush_i;
   logic              disp_valid_i;
   logic              disp_ready_o;
   logic [OP_W-1:0]   disp_op_i;
   logic [PREG_W-1:0] disp_prs1_i;
   logic [PREG_W-1:0] disp_prs2_i;
   logic              disp_prs1_rdy_i;
   logic              disp_prs2_rdy_i;
   logic [PREG_W-1:0] disp_prd_i;
   logic              cdb_en_i;
   logic [PREG_W-1:0] cdb_reg_addr_i;
   logic              iss_valid_o;
   logic              iss_ready_i;
   logic [OP_W-1:0]   iss_op_o;
   logic [PREG_W-1:0] iss_prs1_o;
   logic [PREG_W-1:0] iss_prs2_o;
   logic [PREG_W-1:0] iss_prd_o;
   logic [CW-1:0]     count_o;

   modport master (
      output flush_i, disp_valid_i, disp_op_i, disp_prs1_i, disp_prs2_i,
             disp_prs1_rdy_i, disp_prs2_rdy_i, disp_prd_i,
             cdb_en_i, cdb_reg_addr_i, iss_ready_i,
      input  disp_ready_o, iss_valid_o, iss_op_o, iss_prs1_o, iss_prs2_o,
             iss_prd_o, count_o
   );

   modport slave (
      input  flush_i, disp_valid_i, disp_op_i, disp_prs1_i, disp_prs2_i,
             disp_prs1_rdy_i, disp_prs2_rdy_i, disp_prd_i,
             cdb_en_i, cdb_reg_addr_i, iss_ready_i,
      output disp_ready_o, iss_valid_o, iss_op_o, iss_prs1_o, iss_prs2_o,
             iss_prd_o, count_o
   );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: out-of-order issue queue, CDB wakeup, age-matrix oldest-ready select (IQ_FAST_WAKEUP_EN).
// Latency: dispatch->issue 1 cycle; wakeup->issue 1 cycle, 0 with IQ_FAST_WAKEUP_EN.
// Backpressure: disp_ready_o low at DEPTH entries; iss_ready_i low holds all entries.
module issue_queue #(
   parameter int DEPTH  = 8,
   parameter int PREG_W = 5,
   parameter int OP_W   = 8
) (
   input  logic         clk_i,
   input  logic         reset_ni,
   issue_queue_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0]  r_vld;
   logic [DEPTH-1:0]  r_rdy1;
   logic [DEPTH-1:0]  r_rdy2;
   logic [OP_W-1:0]   r_op   [DEPTH];
   logic [PREG_W-1:0] r_prs1 [DEPTH];
   logic [PREG_W-1:0] r_prs2 [DEPTH];
   logic [PREG_W-1:0] r_prd  [DEPTH];
   logic [DEPTH-1:0]  r_age  [DEPTH];
   logic [CW-1:0]     r_count;

   logic [DEPTH-1:0]  w_rdy1;
   logic [DEPTH-1:0]  w_rdy2;
   logic [DEPTH-1:0]  w_elig;
   logic [DEPTH-1:0]  w_sel;
   logic [DEPTH-1:0]  w_free;
   logic              w_disp_fire;
   logic              w_iss_fire;
   logic              w_cap1;
   logic              w_cap2;
   logic [OP_W-1:0]   w_iss_op;
   logic [PREG_W-1:0] w_iss_prs1;
   logic [PREG_W-1:0] w_iss_prs2;
   logic [PREG_W-1:0] w_iss_prd;

   assign bus.disp_ready_o = (r_count < CW'(DEPTH)) & reset_ni;
   assign w_disp_fire      = bus.disp_valid_i & bus.disp_ready_o;
   assign w_iss_fire       = bus.iss_valid_o & bus.iss_ready_i;

   // One-hot lowest clear bit of r_vld.
   assign w_free = ~r_vld & (r_vld + DEPTH'(1));

   assign w_cap1 = bus.disp_prs1_rdy_i | (bus.disp_prs1_i == '0) |
                   (bus.cdb_en_i & (bus.cdb_reg_addr_i == bus.disp_prs1_i));
   assign w_cap2 = bus.disp_prs2_rdy_i | (bus.disp_prs2_i == '0) |
                   (bus.cdb_en_i & (bus.cdb_reg_addr_i == bus.disp_prs2_i));

   always_comb begin
      w_rdy1 = r_rdy1;
      w_rdy2 = r_rdy2;
`ifdef IQ_FAST_WAKEUP_EN
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.cdb_en_i && (r_prs1[i] == bus.cdb_reg_addr_i)) w_rdy1[i] = 1'b1;
         if (bus.cdb_en_i && (r_prs2[i] == bus.cdb_reg_addr_i)) w_rdy2[i] = 1'b1;
      end
`endif
      w_elig = r_vld & w_rdy1 & w_rdy2;
   end

   // An eligible entry wins unless some other eligible entry is older than it.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_sel[i] = w_elig[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (w_elig[j] && r_age[j][i]) w_sel[i] = 1'b0;
         end
      end
   end

   always_comb begin
      w_iss_op   = '0;
      w_iss_prs1 = '0;
      w_iss_prs2 = '0;
      w_iss_prd  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_sel[i]) begin
            w_iss_op   = w_iss_op   | r_op[i];
            w_iss_prs1 = w_iss_prs1 | r_prs1[i];
            w_iss_prs2 = w_iss_prs2 | r_prs2[i];
            w_iss_prd  = w_iss_prd  | r_prd[i];
         end
      end
   end

   assign bus.iss_valid_o = |w_sel;
   assign bus.iss_op_o    = w_iss_op;
   assign bus.iss_prs1_o  = w_iss_prs1;
   assign bus.iss_prs2_o  = w_iss_prs2;
   assign bus.iss_prd_o   = w_iss_prd;
   assign bus.count_o     = r_count;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_vld   <= '0;
         r_rdy1  <= '0;
         r_rdy2  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_op[i]   <= '0;
            r_prs1[i] <= '0;
            r_prs2[i] <= '0;
            r_prd[i]  <= '0;
            r_age[i]  <= '0;
         end
      end else if (bus.flush_i) begin
         r_vld   <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.cdb_en_i && r_vld[i]) begin
               if (r_prs1[i] == bus.cdb_reg_addr_i) r_rdy1[i] <= 1'b1;
               if (r_prs2[i] == bus.cdb_reg_addr_i) r_rdy2[i] <= 1'b1;
            end
            if (w_iss_fire && w_sel[i]) r_vld[i] <= 1'b0;
            if (w_disp_fire && w_free[i]) begin
               r_vld[i]  <= 1'b1;
               r_op[i]   <= bus.disp_op_i;
               r_prs1[i] <= bus.disp_prs1_i;
               r_prs2[i] <= bus.disp_prs2_i;
               r_prd[i]  <= bus.disp_prd_i;
               r_rdy1[i] <= w_cap1;
               r_rdy2[i] <= w_cap2;
            end
         end
         // New entry is younger than every currently valid entry.
         if (w_disp_fire) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (w_free[j]) r_age[j] <= '0;
               else           r_age[j] <= r_age[j] | (w_free & {DEPTH{r_vld[j]}});
            end
         end
         case ({w_disp_fire, w_iss_fire})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: scoreboard bench; expected issues queued at dispatch, checked on each issue transfer.
// Also checks occupancy, ready and valid at reset, full, flush and wakeup boundaries.
module tb_issue_queue;
   localparam int DEPTH  = 8;
   localparam int PREG_W = 5;
   localparam int OP_W   = 8;
   localparam int RW     = OP_W + 3 * PREG_W;
`ifdef IQ_FAST_WAKEUP_EN
   localparam logic FAST = 1'b1;
`else
   localparam logic FAST = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_ni;
   int   n_vec = 0;
   int   n_err = 0;
   logic [RW-1:0] sb [$];

   always #5 clk = ~clk;

   issue_queue_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .OP_W(OP_W)) bus ();

   issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .OP_W(OP_W)) dut (
      .clk_i    (clk),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] rec(input logic [7:0] op, input logic [4:0] p1,
                                         input logic [4:0] p2, input logic [4:0] rd);
      return {op, p1, p2, rd};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [7:0] op, input logic [4:0] p1, input logic r1,
                       input logic [4:0] p2, input logic r2, input logic [4:0] rd);
      bus.disp_valid_i    = 1'b1;
      bus.disp_op_i       = op;
      bus.disp_prs1_i     = p1;
      bus.disp_prs1_rdy_i = r1;
      bus.disp_prs2_i     = p2;
      bus.disp_prs2_rdy_i = r2;
      bus.disp_prd_i      = rd;
      step();
      bus.disp_valid_i    = 1'b0;
   endtask

   // Issue monitor: every transfer must match the oldest pending expectation.
   always @(negedge clk) begin
      if (reset_ni && bus.iss_valid_o && bus.iss_ready_i) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0)
            chk("issue_payload",
                32'({bus.iss_op_o, bus.iss_prs1_o, bus.iss_prs2_o, bus.iss_prd_o}),
                32'(sb.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_ni            = 1'b0;
      bus.flush_i         = 1'b0;
      bus.disp_valid_i    = 1'b1;
      bus.disp_op_i       = 8'h5a;
      bus.disp_prs1_i     = '0;
      bus.disp_prs2_i     = '0;
      bus.disp_prs1_rdy_i = 1'b1;
      bus.disp_prs2_rdy_i = 1'b1;
      bus.disp_prd_i      = 5'd1;
      bus.cdb_en_i        = 1'b0;
      bus.cdb_reg_addr_i  = '0;
      bus.iss_ready_i     = 1'b1;

      // Reset held with dispatch requested
      repeat (3) begin
         @(negedge clk);
         chk("rst_count", 32'(bus.count_o), 32'd0);
         chk("rst_iss_valid", 32'(bus.iss_valid_o), 32'd0);
         chk("rst_disp_ready", 32'(bus.disp_ready_o), 32'd0);
      end
      step();
      bus.disp_valid_i = 1'b0;
      reset_ni = 1'b1;
      @(negedge clk);
      chk("post_rst_disp_ready", 32'(bus.disp_ready_o), 32'd1);
      chk("rst_iss_payload", 32'({bus.iss_op_o, bus.iss_prd_o}), 32'd0);

      // Ready dispatch, no same-cycle bypass
      step();
      sb.push_back(rec(8'h11, 5'd3, 5'd4, 5'd9));
      bus.disp_valid_i = 1'b1;
      bus.disp_op_i = 8'h11; bus.disp_prs1_i = 5'd3; bus.disp_prs2_i = 5'd4;
      bus.disp_prs1_rdy_i = 1'b1; bus.disp_prs2_rdy_i = 1'b1; bus.disp_prd_i = 5'd9;
      @(negedge clk);
      chk("no_bypass", 32'(bus.iss_valid_o), 32'd0);
      step();
      bus.disp_valid_i = 1'b0;
      @(negedge clk);
      chk("ready_iss_valid", 32'(bus.iss_valid_o), 32'd1);
      chk("ready_count1", 32'(bus.count_o), 32'd1);
      step();
      @(negedge clk);
      chk("ready_count0", 32'(bus.count_o), 32'd0);
      chk("ready_empty", 32'(bus.iss_valid_o), 32'd0);

      // Wakeup via CDB two cycles after dispatch; tag 0 source counts as ready
      step();
      sb.push_back(rec(8'h22, 5'd7, 5'd0, 5'd10));
      disp(8'h22, 5'd7, 1'b0, 5'd0, 1'b0, 5'd10);
      @(negedge clk);
      chk("wait_not_ready", 32'(bus.iss_valid_o), 32'd0);
      step();
      bus.cdb_en_i = 1'b1; bus.cdb_reg_addr_i = 5'd7;
      @(negedge clk);
      chk("wake_cycle", 32'(bus.iss_valid_o), 32'(FAST));
      step();
      bus.cdb_en_i = 1'b0;
      @(negedge clk);
      chk("wake_next_cycle", 32'(bus.iss_valid_o), 32'(!FAST));
      step();
      @(negedge clk);
      chk("wake_count0", 32'(bus.count_o), 32'd0);

      // CDB broadcast in the dispatch cycle itself
      step();
      sb.push_back(rec(8'h33, 5'd7, 5'd8, 5'd11));
      bus.cdb_en_i = 1'b1; bus.cdb_reg_addr_i = 5'd7;
      disp(8'h33, 5'd7, 1'b0, 5'd8, 1'b1, 5'd11);
      bus.cdb_en_i = 1'b0;
      @(negedge clk);
      chk("same_cycle_wake", 32'(bus.iss_valid_o), 32'd1);
      step();

      // Fill to DEPTH under backpressure
      bus.iss_ready_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         sb.push_back(rec(8'h40 + 8'(i), 5'(i + 1), 5'(i + 10), 5'(i + 20)));
         disp(8'h40 + 8'(i), 5'(i + 1), 1'b1, 5'(i + 10), 1'b1, 5'(i + 20));
      end
      @(negedge clk);
      chk("full_disp_ready", 32'(bus.disp_ready_o), 32'd0);
      chk("full_count", 32'(bus.count_o), 32'd8);
      step();
      bus.disp_valid_i = 1'b1; bus.disp_op_i = 8'hee;
      bus.iss_ready_i = 1'b1;
      @(negedge clk);
      chk("full_ready_during_issue", 32'(bus.disp_ready_o), 32'd0);
      step();
      bus.disp_valid_i = 1'b0;
      bus.iss_ready_i = 1'b0;
      @(negedge clk);
      chk("pulse_count", 32'(bus.count_o), 32'd7);
      chk("pulse_disp_ready", 32'(bus.disp_ready_o), 32'd1);
      step();
      bus.iss_ready_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.count_o == 0) break;
         step();
      end
      chk("drain_count", 32'(bus.count_o), 32'd0);
      step();

      // Age order: A waits on tag 5, B and C ready
      bus.iss_ready_i = 1'b0;
      sb.push_back(rec(8'hb2, 5'd1, 5'd2, 5'd12));
      sb.push_back(rec(8'ha1, 5'd5, 5'd6, 5'd11));
      sb.push_back(rec(8'hc3, 5'd3, 5'd4, 5'd13));
      disp(8'ha1, 5'd5, 1'b0, 5'd6, 1'b1, 5'd11);
      disp(8'hb2, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12);
      disp(8'hc3, 5'd3, 1'b1, 5'd4, 1'b1, 5'd13);
      bus.iss_ready_i = 1'b1;
      @(negedge clk);
      chk("age_first_valid", 32'(bus.iss_valid_o), 32'd1);
      step();
      bus.iss_ready_i = 1'b0;
      bus.cdb_en_i = 1'b1; bus.cdb_reg_addr_i = 5'd5;
      step();
      bus.cdb_en_i = 1'b0;
      bus.iss_ready_i = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("age_count0", 32'(bus.count_o), 32'd0);
      step();

      // Flush with three held entries plus a same-cycle dispatch
      bus.iss_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) disp(8'h60 + 8'(i), 5'(i + 1), 1'b1, 5'd2, 1'b1, 5'd3);
      bus.flush_i = 1'b1;
      disp(8'h6f, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
      bus.flush_i = 1'b0;
      bus.iss_ready_i = 1'b1;
      @(negedge clk);
      chk("flush_count", 32'(bus.count_o), 32'd0);
      chk("flush_no_issue", 32'(bus.iss_valid_o), 32'd0);
      step();
      @(negedge clk);
      chk("flush_no_issue2", 32'(bus.iss_valid_o), 32'd0);
      step();

      // Reset asserted mid-operation
      bus.iss_ready_i = 1'b0;
      disp(8'h71, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
      disp(8'h72, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4);
      #3 reset_ni = 1'b0;
      #1;
      chk("midrst_count", 32'(bus.count_o), 32'd0);
      chk("midrst_iss_valid", 32'(bus.iss_valid_o), 32'd0);
      chk("midrst_disp_ready", 32'(bus.disp_ready_o), 32'd0);
      step();
      reset_ni = 1'b1;
      bus.iss_ready_i = 1'b1;
      @(negedge clk);
      chk("midrst_after_valid", 32'(bus.iss_valid_o), 32'd0);
      chk("midrst_after_ready", 32'(bus.disp_ready_o), 32'd1);
      step();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
